// File: rtl/ddr_prbs_chk.sv
// DDR read-data checker: prefetches expected PRBS words through a credit-limited FIFO and
// compares them lane-by-lane against AXI read beats, accumulating error statistics.
module ddr_prbs_chk #(
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned EXP_DEPTH      = 4,
  localparam int unsigned CH_NUM        = AXI_DATA_WIDTH / 32
) (
  input  logic                      i_clk_sys,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [31:0]               i_beat_num,
  output logic [CH_NUM-1:0]         o_prbs_en,
  input  logic                      i_prbs_vld,
  input  logic [AXI_DATA_WIDTH-1:0] i_prbs_data,
  input  logic                      i_rd_vld,
  input  logic [AXI_DATA_WIDTH-1:0] i_rd_data,
  output logic                      o_rd_rdy,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [31:0]               o_beat_cnt,
  output logic [31:0]               o_err_cnt,
  output logic [CH_NUM-1:0]         o_lane_err,
  output logic                      o_first_err_vld,
  output logic [31:0]               o_first_err_idx
);

  localparam int unsigned PtrW = $clog2(EXP_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthLim = EXP_DEPTH[CntW:0];

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [31:0]         r_beat_num, w_beat_num_d;
  logic [31:0]         r_req_cnt, w_req_cnt_d;
  logic [31:0]         r_beat_cnt, w_beat_cnt_d;
  logic [31:0]         r_err_cnt, w_err_cnt_d;
  logic [CH_NUM-1:0]   r_lane_err, w_lane_err_d;
  logic                r_first_err_vld, w_first_err_vld_d;
  logic [31:0]         r_first_err_idx, w_first_err_idx_d;
  logic [CntW-1:0]     r_occ, w_occ_d;
  logic [CntW-1:0]     r_inflight, w_inflight_d;
  logic [PtrW-1:0]     r_wptr, w_wptr_d;
  logic [PtrW-1:0]     r_rptr, w_rptr_d;
  logic                r_prbs_en, w_prbs_en_d;
  logic                r_rd_rdy, w_rd_rdy_d;
  logic                r_pass, w_pass_d;

  logic [AXI_DATA_WIDTH-1:0] r_mem [EXP_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] w_head;
  logic [CH_NUM-1:0]         w_mismatch;
  logic                      w_push, w_pop, w_req;
  logic [CntW:0]             w_credit;

  assign w_head = r_mem[r_rptr];
  assign w_req  = r_prbs_en;
  assign w_pop  = r_rd_rdy && i_rd_vld;
  // Words arriving with no outstanding request (e.g. after a reset) are discarded.
  assign w_push = (r_state == StRun) && i_prbs_vld && (r_inflight != '0);

  always_comb begin
    w_mismatch = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      w_mismatch[i] = (i_rd_data[32*i +: 32] != w_head[32*i +: 32]);
    end
  end

  always_comb begin
    w_state_d         = r_state;
    w_beat_num_d      = r_beat_num;
    w_req_cnt_d       = r_req_cnt;
    w_beat_cnt_d      = r_beat_cnt;
    w_err_cnt_d       = r_err_cnt;
    w_lane_err_d      = r_lane_err;
    w_first_err_vld_d = r_first_err_vld;
    w_first_err_idx_d = r_first_err_idx;
    w_occ_d           = r_occ;
    w_inflight_d      = r_inflight;
    w_wptr_d          = r_wptr;
    w_rptr_d          = r_rptr;

    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_beat_num_d      = i_beat_num;
          w_req_cnt_d       = '0;
          w_beat_cnt_d      = '0;
          w_err_cnt_d       = '0;
          w_lane_err_d      = '0;
          w_first_err_vld_d = 1'b0;
          w_first_err_idx_d = '0;
          w_occ_d           = '0;
          w_inflight_d      = '0;
          w_wptr_d          = '0;
          w_rptr_d          = '0;
          w_state_d         = (i_beat_num != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (w_req) begin
          w_req_cnt_d = r_req_cnt + 32'd1;
        end
        unique case ({w_req, w_push})
          2'b10:   w_inflight_d = r_inflight + CntW'(1);
          2'b01:   w_inflight_d = r_inflight - CntW'(1);
          default: w_inflight_d = r_inflight;
        endcase
        w_occ_d = r_occ + CntW'(w_push) - CntW'(w_pop);
        if (w_push) begin
          w_wptr_d = r_wptr + PtrW'(1);
        end
        if (w_pop) begin
          w_rptr_d     = r_rptr + PtrW'(1);
          w_beat_cnt_d = r_beat_cnt + 32'd1;
          w_lane_err_d = r_lane_err | w_mismatch;
          if (w_mismatch != '0) begin
            if (r_err_cnt != '1) begin
              w_err_cnt_d = r_err_cnt + 32'd1;
            end
            if (!r_first_err_vld) begin
              w_first_err_vld_d = 1'b1;
              w_first_err_idx_d = r_beat_cnt;
            end
          end
          if (w_beat_cnt_d == r_beat_num) begin
            w_state_d = StDone;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Registered outputs are derived from next-state values so they line up with the state.
    w_credit    = {1'b0, w_occ_d} + {1'b0, w_inflight_d};
    w_prbs_en_d = (w_state_d == StRun) && (w_credit < DepthLim) && (w_req_cnt_d < w_beat_num_d);
    w_rd_rdy_d  = (w_state_d == StRun) && (w_occ_d != '0);
    w_pass_d    = (w_state_d == StDone) && (w_err_cnt_d == '0);
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset) begin
      r_state         <= StIdle;
      r_beat_num      <= '0;
      r_req_cnt       <= '0;
      r_beat_cnt      <= '0;
      r_err_cnt       <= '0;
      r_lane_err      <= '0;
      r_first_err_vld <= 1'b0;
      r_first_err_idx <= '0;
      r_occ           <= '0;
      r_inflight      <= '0;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_prbs_en       <= 1'b0;
      r_rd_rdy        <= 1'b0;
      r_pass          <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_beat_num      <= w_beat_num_d;
      r_req_cnt       <= w_req_cnt_d;
      r_beat_cnt      <= w_beat_cnt_d;
      r_err_cnt       <= w_err_cnt_d;
      r_lane_err      <= w_lane_err_d;
      r_first_err_vld <= w_first_err_vld_d;
      r_first_err_idx <= w_first_err_idx_d;
      r_occ           <= w_occ_d;
      r_inflight      <= w_inflight_d;
      r_wptr          <= w_wptr_d;
      r_rptr          <= w_rptr_d;
      r_prbs_en       <= w_prbs_en_d;
      r_rd_rdy        <= w_rd_rdy_d;
      r_pass          <= w_pass_d;
    end
  end

  // Storage needs no reset; the pointers and occupancy define what is valid.
  always_ff @(posedge i_clk_sys) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_prbs_data;
    end
  end

  assign o_prbs_en       = {CH_NUM{r_prbs_en}};
  assign o_rd_rdy        = r_rd_rdy;
  assign o_busy          = (r_state == StRun);
  assign o_done          = (r_state == StDone);
  assign o_pass          = r_pass;
  assign o_beat_cnt      = r_beat_cnt;
  assign o_err_cnt       = r_err_cnt;
  assign o_lane_err      = r_lane_err;
  assign o_first_err_vld = r_first_err_vld;
  assign o_first_err_idx = r_first_err_idx;

endmodule
